// File: rtl/stonyman_pkg.sv
// Shared state encoding, default geometry/timing constants and
// the per-state timer load helper for the Stonyman capture controller.
package stonyman_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_RST_ROW,
        S_RST_COL,
        S_SETTLE,
        S_CONV,
        S_WRITE,
        S_INC_COL,
        S_INC_ROW
    } state_e;

    localparam int ROWS_DEF    = 112;
    localparam int COLS_DEF    = 112;
    localparam int PULSE_W_DEF = 2;
    localparam int SETTLE_DEF  = 8;

    // Timer counts down to zero, so a state lasting N cycles loads N-1.
    function automatic logic [7:0] timer_load(state_e s, int pulse_w, int settle);
        logic [7:0] v;
        v = 8'd0;
        unique case (s)
            S_RST_ROW, S_RST_COL,
            S_INC_COL, S_INC_ROW: v = 8'(pulse_w - 1);
            S_SETTLE:             v = 8'(settle - 1);
            default:              v = 8'd0;
        endcase
        return v;
    endfunction

endpackage

// File: rtl/stonyman_capture_ctrl_if.sv
// Load/count/done handshake between the capture FSM and its
// strobe/settle down-counter.
interface stonyman_capture_ctrl_if;

    logic       load;
    logic [7:0] load_val;
    logic       done;

    modport master (output load, output load_val, input  done);
    modport slave  (input  load, input  load_val, output done);

endinterface

// File: rtl/stonyman_pulse_timer.sv
// 8-bit down-counter: loaded on state entry, done when it reaches zero.
module stonyman_pulse_timer (
    input  logic                     clk,
    input  logic                     rst_n,
    stonyman_capture_ctrl_if.slave   tmr
);

    logic [7:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (tmr.load) begin
            cnt_d = tmr.load_val;
        end else if (cnt_q != 8'd0) begin
            cnt_d = cnt_q - 8'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= 8'd0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tmr.done = (cnt_q == 8'd0);

endmodule

// File: rtl/stonyman_capture_ctrl.sv
// Stonyman image-sensor frame capture: row/column strobes, ADC
// handshake and FIFO write, all outputs registered.
module stonyman_capture_ctrl
    import stonyman_pkg::*;
#(
    parameter int ROWS    = ROWS_DEF,
    parameter int COLS    = COLS_DEF,
    parameter int PULSE_W = PULSE_W_DEF,
    parameter int SETTLE  = SETTLE_DEF
) (
    input  logic       PCLK,
    input  logic       PRESERN,
    input  logic       START_CAPTURE,
    output logic       BUSY,
    output logic       RESV,
    output logic       INCV,
    output logic       RESP,
    output logic       INCP,
    output logic       ADC_START,
    input  logic       ADC_DONE,
    input  logic [7:0] ADC_DATA,
    input  logic       FULL,
    output logic       WREN,
    output logic [7:0] FIFO_DATA
);

    localparam logic [6:0] ROW_LAST = 7'(ROWS - 1);
    localparam logic [6:0] COL_LAST = 7'(COLS - 1);

    state_e     state_q, state_d;
    logic [6:0] row_q, row_d;
    logic [6:0] col_q, col_d;
    logic [7:0] fifo_data_q, fifo_data_d;
    logic       wren_q, wren_d;
    logic       busy_q, busy_d;
    logic       resv_q, resv_d;
    logic       resp_q, resp_d;
    logic       incv_q, incv_d;
    logic       incp_q, incp_d;
    logic       adc_start_q, adc_start_d;
    logic       entering;

    stonyman_capture_ctrl_if u_tif ();

    stonyman_pulse_timer u_timer (
        .clk   (PCLK),
        .rst_n (PRESERN),
        .tmr   (u_tif.slave)
    );

    always_comb begin
        state_d     = state_q;
        row_d       = row_q;
        col_d       = col_q;
        fifo_data_d = fifo_data_q;
        wren_d      = 1'b1;
        unique case (state_q)
            S_IDLE: begin
                if (!START_CAPTURE) begin
                    state_d = S_RST_ROW;
                    row_d   = 7'd0;
                    col_d   = 7'd0;
                end
            end
            S_RST_ROW: if (u_tif.done) state_d = S_RST_COL;
            S_RST_COL: if (u_tif.done) state_d = S_SETTLE;
            S_SETTLE:  if (u_tif.done) state_d = S_CONV;
            S_CONV: begin
                // ADC_DONE in the request cycle belongs to a stale conversion
                if (!adc_start_q && ADC_DONE) begin
                    fifo_data_d = ADC_DATA;
                    state_d     = S_WRITE;
                end
            end
            S_WRITE: begin
                // the WREN-low cycle stays in WRITE so no strobe overlaps it
                if (!wren_q) begin
                    if (col_q < COL_LAST) begin
                        col_d   = col_q + 7'd1;
                        state_d = S_INC_COL;
                    end else if (row_q < ROW_LAST) begin
                        row_d   = row_q + 7'd1;
                        col_d   = 7'd0;
                        state_d = S_INC_ROW;
                    end else begin
                        state_d = S_IDLE;
                    end
                end else if (!FULL) begin
                    wren_d = 1'b0;
                end
            end
            S_INC_COL: if (u_tif.done) state_d = S_SETTLE;
            S_INC_ROW: if (u_tif.done) state_d = S_RST_COL;
            default:   state_d = S_IDLE;
        endcase
    end

    always_comb begin
        entering       = (state_d != state_q);
        u_tif.load     = entering;
        u_tif.load_val = timer_load(state_d, PULSE_W, SETTLE);
        busy_d         = (state_d != S_IDLE);
        resv_d         = (state_d == S_RST_ROW);
        resp_d         = (state_d == S_RST_COL);
        incp_d         = (state_d == S_INC_COL);
        incv_d         = (state_d == S_INC_ROW);
        adc_start_d    = (state_d == S_CONV) && entering;
    end

    always_ff @(posedge PCLK or negedge PRESERN) begin
        if (!PRESERN) begin
            state_q     <= S_IDLE;
            row_q       <= 7'd0;
            col_q       <= 7'd0;
            fifo_data_q <= 8'd0;
            wren_q      <= 1'b1;
            busy_q      <= 1'b0;
            resv_q      <= 1'b0;
            resp_q      <= 1'b0;
            incv_q      <= 1'b0;
            incp_q      <= 1'b0;
            adc_start_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            row_q       <= row_d;
            col_q       <= col_d;
            fifo_data_q <= fifo_data_d;
            wren_q      <= wren_d;
            busy_q      <= busy_d;
            resv_q      <= resv_d;
            resp_q      <= resp_d;
            incv_q      <= incv_d;
            incp_q      <= incp_d;
            adc_start_q <= adc_start_d;
        end
    end

    assign BUSY      = busy_q;
    assign RESV      = resv_q;
    assign RESP      = resp_q;
    assign INCV      = incv_q;
    assign INCP      = incp_q;
    assign ADC_START = adc_start_q;
    assign WREN      = wren_q;
    assign FIFO_DATA = fifo_data_q;

endmodule

// File: doc/stonyman_capture_ctrl.md
STONYMAN_CAPTURE_CTRL -- requirements
Module: stonyman_capture_ctrl

Interface
REQ-001 SHALL have parameter ROWS, default 112, meaning pixel rows scanned per frame (1..128).
REQ-002 SHALL have parameter COLS, default 112, meaning pixels per row (1..128).
REQ-003 SHALL have parameter PULSE_W, default 2, meaning high time in PCLK cycles of every sensor strobe (1..255).
REQ-004 SHALL have parameter SETTLE, default 8, meaning PCLK cycles waited after pixel selection before ADC start (1..255).
REQ-005 SHALL have ports: PCLK  in  1  clock; PRESERN  in  1  reset, asynchronous, active-low.
REQ-006 SHALL have ports: START_CAPTURE  in  1  frame request, active low; BUSY  out  1  frame in progress.
REQ-007 SHALL have ports: RESV, INCV, RESP, INCP  out  1 each  sensor row-reset, row-increment, column-reset, column-increment strobes, active high.
REQ-008 SHALL have ports: ADC_START  out  1  conversion request; ADC_DONE  in  1  conversion complete; ADC_DATA  in  8  conversion result.
REQ-009 SHALL have ports: FULL  in  1  FIFO full; WREN  out  1  FIFO write, active low; FIFO_DATA  out  8  pixel to FIFO.

Function
REQ-010 SHALL implement states IDLE, RST_ROW, RST_COL, SETTLE, CONV, WRITE, INC_COL, INC_ROW.
REQ-011 SHALL leave IDLE for RST_ROW when START_CAPTURE is sampled low; RESV SHALL go high in the next cycle.
REQ-012 SHALL hold RESV high for exactly PULSE_W cycles in RST_ROW, then enter RST_COL; RESP SHALL be high for exactly PULSE_W cycles, then enter SETTLE.
REQ-013 SHALL remain in SETTLE exactly SETTLE cycles, then enter CONV.
REQ-014 SHALL assert ADC_START for exactly the first CONV cycle, sample ADC_DONE only from the following cycle, and on ADC_DONE high latch ADC_DATA into FIFO_DATA and enter WRITE.
REQ-015 SHALL in WRITE, while FULL is high, hold WREN high and FIFO_DATA stable (stall, no data loss); in the first cycle with FULL low, drive WREN low for exactly one cycle.
REQ-016 SHALL after the write: if col < COLS-1, increment col and pulse INCP PULSE_W cycles (INC_COL), then return to SETTLE; otherwise, if row < ROWS-1, increment row, clear col, pulse INCV PULSE_W cycles (INC_ROW), then go to RST_COL; otherwise go to IDLE.
REQ-017 SHALL hold 7-bit row and col counters that are never compared beyond ROWS-1/COLS-1 (no wrap within a frame) and are cleared on entry to RST_ROW.
REQ-018 SHALL drive BUSY high in every state except IDLE, and low in the cycle IDLE is re-entered.
REQ-019 SHALL ignore START_CAPTURE outside IDLE; a START_CAPTURE still low on return to IDLE SHALL start a new frame.
REQ-020 SHALL never assert more than one of RESV, RESP, INCV, INCP, ADC_START, or WREN-low in the same cycle.
REQ-021 SHALL emit exactly ROWS*COLS WREN-low pulses per frame, in row-major order.
REQ-022 SHALL use an 8-bit down-counter for pulse and settle timing, loaded on each state entry.

Reset
REQ-023 SHALL on PRESERN low immediately force state IDLE, row=col=timer=0, FIFO_DATA=0, BUSY=0, RESV=INCV=RESP=INCP=ADC_START=0, and WREN=1, including mid-frame; no partial frame resumes.
REQ-024 SHALL register every output (no combinational path from input to output).

Structure
REQ-025 SHALL place the state encoding and the default ROWS/COLS/PULSE_W/SETTLE constants in shared package stonyman_pkg.
REQ-026 SHALL implement strobe/settle timing in one sub-module stonyman_pulse_timer (load, count, done).

Verification (ROWS=2, COLS=3, PULSE_W=2, SETTLE=4; ADC model returns 8'h10+n, ADC_DONE 3 cycles after ADC_START)
REQ-027 SHALL check a full frame with START_CAPTURE low for 1 cycle and FULL=0 -> 1 RESV, 2 RESP, 4 INCP, and 1 INCV pulse, each 2 cycles wide; 6 WREN pulses with data 10..15; then BUSY=0.
REQ-028 SHALL check FULL high for 10 cycles during pixel 2 -> WREN stays high, FIFO_DATA=8'h12 stable, and one write after FULL falls.
REQ-029 SHALL check START_CAPTURE pulsed mid-frame -> no restart, exactly 6 writes.
REQ-030 SHALL check PRESERN asserted during SETTLE of pixel 4 -> all outputs at reset values in the same cycle; a new START gives RESV first and 6 writes.
REQ-031 SHALL check ADC_DONE already high in the ADC_START cycle -> ignored, and the pixel is latched on the next ADC_DONE.
REQ-032 SHALL check START_CAPTURE held low continuously -> back-to-back frames, with RESV at IDLE+1.
